// File: rtl/gene_codec_pkg.sv
// Shared definitions for the NXXXX gene codec: token layout, ASCII codes,
// output word geometry and the expander FSM state encoding.
package gene_codec_pkg;

  // Output word geometry
  localparam int unsigned CHARS_PER_WORD = 20;
  localparam int unsigned WORD_W         = 8 * CHARS_PER_WORD;
  localparam int unsigned IDX_W          = 5;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(CHARS_PER_WORD - 1);
  localparam logic [7:0] PAD_CHAR        = 8'h00;

  // Token layout
  localparam int unsigned TOK_W       = 128;
  localparam int unsigned MAX_LIT     = 32;
  localparam int unsigned TAG_MSB     = 127;
  localparam int unsigned TAG_LSB     = 126;
  localparam int unsigned LIT_CNT_MSB = 69;
  localparam int unsigned LIT_CNT_LSB = 64;
  localparam int unsigned LIT_CNT_W   = LIT_CNT_MSB - LIT_CNT_LSB + 1;
  localparam int unsigned LIT_BITS_W  = 2 * MAX_LIT;
  localparam int unsigned NRUN_LEN_W  = 32;

  localparam logic [1:0] TAG_LIT  = 2'b00;
  localparam logic [1:0] TAG_NRUN = 2'b01;
  localparam logic [1:0] TAG_END  = 2'b10;
  localparam logic [1:0] TAG_RSV  = 2'b11;

  // ASCII nucleotide codes
  localparam logic [7:0] ASCII_A = 8'h41;
  localparam logic [7:0] ASCII_C = 8'h43;
  localparam logic [7:0] ASCII_G = 8'h47;
  localparam logic [7:0] ASCII_T = 8'h54;
  localparam logic [7:0] ASCII_N = 8'h4E;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EMIT_LIT,
    ST_EMIT_N,
    ST_FLUSH
  } state_e;

  // 2-bit base code to ASCII
  function automatic logic [7:0] base_ascii(input logic [1:0] code);
    logic [7:0] r;
    r = ASCII_A;
    case (code)
      2'b00:   r = ASCII_A;
      2'b01:   r = ASCII_C;
      2'b10:   r = ASCII_G;
      default: r = ASCII_T;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nxxxx_packer.sv
// Packs one character per write into a 20-slot register and hands full words
// to a single-entry output register, stalling when that register is occupied.
// Ports: wr/ch = character write, flush = pad and close the stream,
// stall_c/flush_done_c = combinational handshake back to the FSM,
// out_word/out_vld/out_last/out_rdy = registered output handshake.
module nxxxx_packer
  import gene_codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic [7:0]        ch,
  input  logic              flush,
  input  logic              out_rdy,
  output logic              stall_c,
  output logic              flush_done_c,
  output logic [WORD_W-1:0] out_word,
  output logic              out_vld,
  output logic              out_last
);

  logic [CHARS_PER_WORD-1:0][7:0] pack;
  logic [CHARS_PER_WORD-1:0][7:0] pack_wr_c;
  logic [CHARS_PER_WORD-1:0][7:0] pack_pad_c;
  logic [IDX_W-1:0]               idx;
  logic allow_c, take_c, at_end_c, wr_ok_c, fl_xfer_c, fl_mark_c;

  // Transfer permission, stall and next-pack views
  always_comb begin
    allow_c      = !out_vld || out_rdy;
    take_c       = out_vld && out_rdy;
    at_end_c     = (idx == IDX_LAST);
    stall_c      = wr && at_end_c && !allow_c;
    wr_ok_c      = wr && !stall_c;
    // With idx==0 a held word only needs its last flag, so flush never waits.
    flush_done_c = (idx == '0) || allow_c;
    fl_xfer_c    = flush && allow_c;
    fl_mark_c    = flush && (idx == '0) && out_vld && !out_rdy;
    for (int unsigned k = 0; k < CHARS_PER_WORD; k++) begin
      pack_wr_c[k]  = (idx == IDX_W'(k)) ? ch : pack[k];
      pack_pad_c[k] = (IDX_W'(k) < idx) ? pack[k] : PAD_CHAR;
    end
  end

  // Pack register, slot index and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pack     <= '0;
      idx      <= '0;
      out_word <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
    end else begin
      if (take_c) begin
        out_vld  <= 1'b0;
        out_last <= 1'b0;
      end
      if (wr_ok_c) begin
        pack <= pack_wr_c;
        if (at_end_c) begin
          idx      <= '0;
          out_word <= pack_wr_c;
          out_vld  <= 1'b1;
          out_last <= 1'b0;
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end else if (fl_xfer_c) begin
        idx      <= '0;
        out_word <= pack_pad_c;
        out_vld  <= 1'b1;
        out_last <= 1'b1;
      end else if (fl_mark_c) begin
        out_last <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nxxxx_expander.sv
// NXXXX gene-stream decompressor: decodes 128-bit LITERAL / NRUN / END tokens
// into ASCII A/C/G/T/N and emits 160-bit words of 20 characters.
// Ports: in_tok/in_vld/in_rd = token input handshake,
// out_word/out_vld/out_rdy/out_last = word output handshake, err = sticky
// protocol error. Build macro NXXXX_EXP_STATS_EN adds stat_bases/stat_n.
module nxxxx_expander
  import gene_codec_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [TOK_W-1:0]  in_tok,
  input  logic              in_vld,
  output logic              in_rd,
  output logic [WORD_W-1:0] out_word,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic              out_last,
  output logic              err
`ifdef NXXXX_EXP_STATS_EN
  ,
  output logic [31:0]       stat_bases,
  output logic [31:0]       stat_n
`endif
);

  state_e                  state;
  logic [LIT_BITS_W-1:0]   lit_bits;
  logic [LIT_CNT_W-1:0]    lit_rem;
  logic [NRUN_LEN_W-1:0]   n_rem;

  logic                    wr_c, flush_c, stall_c, flush_done_c, adv_c;
  logic [7:0]              ch_c;
  logic [1:0]              tag_c;
  logic [LIT_CNT_W-1:0]    cnt_c;
  logic [NRUN_LEN_W-1:0]   len_c;
  logic                    tok_unused_c;

  // Token field decode and character selection
  always_comb begin
    tag_c        = in_tok[TAG_MSB:TAG_LSB];
    cnt_c        = in_tok[LIT_CNT_MSB:LIT_CNT_LSB];
    len_c        = in_tok[NRUN_LEN_W-1:0];
    tok_unused_c = ^in_tok[TAG_LSB-1:LIT_CNT_MSB+1];
    wr_c         = (state == ST_EMIT_LIT) || (state == ST_EMIT_N);
    flush_c      = (state == ST_FLUSH);
    ch_c         = (state == ST_EMIT_N) ? ASCII_N : base_ascii(lit_bits[1:0]);
    adv_c        = wr_c && !stall_c;
  end

  // Token FSM; in_rd is high exactly while idle and ready to accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      in_rd    <= 1'b0;
      err      <= 1'b0;
      lit_bits <= '0;
      lit_rem  <= '0;
      n_rem    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          in_rd <= 1'b1;
          if (in_vld && in_rd) begin
            case (tag_c)
              TAG_LIT: begin
                if (cnt_c == '0) begin
                  err <= 1'b1;
                end else begin
                  if (cnt_c > LIT_CNT_W'(MAX_LIT)) err <= 1'b1;
                  lit_rem  <= (cnt_c > LIT_CNT_W'(MAX_LIT)) ? LIT_CNT_W'(MAX_LIT) : cnt_c;
                  lit_bits <= in_tok[LIT_BITS_W-1:0];
                  state    <= ST_EMIT_LIT;
                  in_rd    <= 1'b0;
                end
              end
              TAG_NRUN: begin
                if (len_c != '0) begin
                  n_rem <= len_c;
                  state <= ST_EMIT_N;
                  in_rd <= 1'b0;
                end
              end
              TAG_END: begin
                state <= ST_FLUSH;
                in_rd <= 1'b0;
              end
              default: err <= 1'b1;
            endcase
          end
        end
        ST_EMIT_LIT: begin
          if (adv_c) begin
            lit_bits <= lit_bits >> 2;
            lit_rem  <= lit_rem - LIT_CNT_W'(1);
            if (lit_rem == LIT_CNT_W'(1)) begin
              state <= ST_IDLE;
              in_rd <= 1'b1;
            end
          end
        end
        ST_EMIT_N: begin
          if (adv_c) begin
            n_rem <= n_rem - NRUN_LEN_W'(1);
            if (n_rem == NRUN_LEN_W'(1)) begin
              state <= ST_IDLE;
              in_rd <= 1'b1;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_done_c) begin
            state <= ST_IDLE;
            in_rd <= 1'b1;
          end
        end
      endcase
    end
  end

  nxxxx_packer u_packer (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr           (wr_c),
    .ch           (ch_c),
    .flush        (flush_c),
    .out_rdy      (out_rdy),
    .stall_c      (stall_c),
    .flush_done_c (flush_done_c),
    .out_word     (out_word),
    .out_vld      (out_vld),
    .out_last     (out_last)
  );

`ifdef NXXXX_EXP_STATS_EN
  // Emitted-character counters, bumped on each accepted character write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_bases <= '0;
      stat_n     <= '0;
    end else if (adv_c) begin
      if (state == ST_EMIT_N) stat_n <= stat_n + 32'd1;
      else                    stat_bases <= stat_bases + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nxxxx_expander.sv
// Directed bench for nxxxx_expander: table of two-token vectors that each
// yield one word, plus hand sequences for stall, flush, error and reset.
module tb_nxxxx_expander;

  logic         clk, rst_n, in_vld, out_rdy;
  logic [127:0] in_tok;
  logic         in_rd, out_vld, out_last, err;
  logic [159:0] out_word;
`ifdef NXXXX_EXP_STATS_EN
  logic [31:0]  stat_bases, stat_n;
`endif

  int total, bad;
  logic [160:0] q[$];

  nxxxx_expander dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_tok   (in_tok),
    .in_vld   (in_vld),
    .in_rd    (in_rd),
    .out_word (out_word),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_last (out_last),
    .err      (err)
`ifdef NXXXX_EXP_STATS_EN
    ,
    .stat_bases (stat_bases),
    .stat_n     (stat_n)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Words are captured at the negedge before the edge that takes them
  always @(negedge clk) begin
    if (out_vld && out_rdy) q.push_back({out_last, out_word});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [127:0] a;
    logic [127:0] b;
    logic [159:0] exp_w;
    logic         exp_last;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  function automatic logic [127:0] lit(input logic [5:0] cnt, input logic [63:0] bits);
    logic [127:0] t;
    t = '0; t[127:126] = 2'b00; t[69:64] = cnt; t[63:0] = bits;
    return t;
  endfunction

  function automatic logic [127:0] nrun(input logic [31:0] n);
    logic [127:0] t;
    t = '0; t[127:126] = 2'b01; t[31:0] = n;
    return t;
  endfunction

  function automatic logic [127:0] endt();
    logic [127:0] t;
    t = '0; t[127:126] = 2'b10;
    return t;
  endfunction

  function automatic logic [127:0] rsv();
    logic [127:0] t;
    t = '0; t[127:126] = 2'b11; t[31:0] = 32'd7; t[69:64] = 6'd4;
    return t;
  endfunction

  function automatic string rep(input string s, input int n);
    string r;
    r = "";
    for (int i = 0; i < n; i++) r = {r, s};
    return r;
  endfunction

  // Expected word from a character string; unused slots are zero padding
  function automatic logic [159:0] mkw(input string s);
    logic [159:0] w;
    w = '0;
    for (int i = 0; i < 20; i++) if (i < s.len()) w[8*i +: 8] = s[i];
    return w;
  endfunction

  task automatic chk(input string name, input logic [159:0] got, input logic [159:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", name, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [127:0] t);
    int n;
    n = 0;
    in_tok = t;
    in_vld = 1'b1;
    @(negedge clk);
    while (!in_rd && n < 300) begin @(negedge clk); n++; end
    if (!in_rd) begin
      total++; bad++;
      $display("FAIL send_timeout: in_rd=%0b after %0d cycles want 1", in_rd, n);
    end
    @(posedge clk); #1;
    in_vld = 1'b0;
  endtask

  task automatic wait_words(input int n, input string name);
    int c;
    c = 0;
    while (q.size() < n && c < 400) begin @(posedge clk); #1; c++; end
    total++;
    if (q.size() < n) begin
      bad++;
      $display("FAIL %s: words=%0d want=%0d", name, q.size(), n);
    end
  endtask

  task automatic pop_chk(input string name, input logic [159:0] w, input logic l);
    logic [160:0] e;
    if (q.size() == 0) begin
      total++; bad++;
      $display("FAIL %s: words=0 want=1", name);
    end else begin
      e = q.pop_front();
      chk({name, "_word"}, e[159:0], w);
      chk({name, "_last"}, 160'(e[160]), 160'(l));
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0; in_vld = 1'b0; in_tok = '0; out_rdy = 1'b1;

    vecs[0] = '{lit(6'd4, 64'hE4), nrun(32'd16), mkw({"ACGT", rep("N", 16)}), 1'b0};
    vecs[1] = '{nrun(32'd5), endt(), mkw("NNNNN"), 1'b1};
    vecs[2] = '{lit(6'd20, 64'h0), nrun(32'd0), mkw(rep("A", 20)), 1'b0};
    vecs[3] = '{lit(6'd3, 64'h27), endt(), mkw("TCG"), 1'b1};
    vecs[4] = '{nrun(32'd0), endt(), mkw(""), 1'b1};
    vecs[5] = '{lit(6'd20, 64'h1B1B1B1B1B), nrun(32'd0), mkw(rep("TGCA", 5)), 1'b0};
    vecs[6] = '{lit(6'd16, 64'hFFFFFFFF), nrun(32'd4), mkw({rep("T", 16), "NNNN"}), 1'b0};

    // Reset state
    #2;
    chk("rst_in_rd", 160'(in_rd), 160'(0));
    chk("rst_out_vld", 160'(out_vld), 160'(0));
    chk("rst_out_last", 160'(out_last), 160'(0));
    chk("rst_out_word", out_word, 160'(0));
    chk("rst_err", 160'(err), 160'(0));
`ifdef NXXXX_EXP_STATS_EN
    chk("rst_stat_bases", 160'(stat_bases), 160'(0));
    chk("rst_stat_n", 160'(stat_n), 160'(0));
`endif
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b1;
    cycles(2);
    chk("idle_in_rd", 160'(in_rd), 160'(1));

    // Table: two tokens each producing exactly one word
    for (int i = 0; i < NV; i++) begin
      send(vecs[i].a);
      send(vecs[i].b);
      wait_words(1, $sformatf("vec%0d_arrive", i));
      cycles(5);
      chk($sformatf("vec%0d_count", i), 160'(q.size()), 160'(1));
      pop_chk($sformatf("vec%0d", i), vecs[i].exp_w, vecs[i].exp_last);
    end
    chk("tbl_err", 160'(err), 160'(0));

    // NRUN 45 then END: two full words and a padded last word
    q.delete();
    send(nrun(32'd45));
    send(endt());
    wait_words(3, "n45_arrive");
    cycles(5);
    chk("n45_count", 160'(q.size()), 160'(3));
    pop_chk("n45_w0", mkw(rep("N", 20)), 1'b0);
    pop_chk("n45_w1", mkw(rep("N", 20)), 1'b0);
    pop_chk("n45_w2", mkw(rep("N", 5)), 1'b1);

    // NRUN 40 under 30 cycles of backpressure
    q.delete();
    out_rdy = 1'b0;
    send(nrun(32'd40));
    cycles(22);
    chk("bp_vld_early", 160'(out_vld), 160'(1));
    chk("bp_word_early", out_word, mkw(rep("N", 20)));
    cycles(8);
    chk("bp_vld_late", 160'(out_vld), 160'(1));
    chk("bp_word_late", out_word, mkw(rep("N", 20)));
    chk("bp_in_rd", 160'(in_rd), 160'(0));
    chk("bp_none_taken", 160'(q.size()), 160'(0));
    out_rdy = 1'b1;
    wait_words(2, "bp_arrive");
    cycles(5);
    chk("bp_count", 160'(q.size()), 160'(2));
    pop_chk("bp_w0", mkw(rep("N", 20)), 1'b0);
    pop_chk("bp_w1", mkw(rep("N", 20)), 1'b0);

    // Reserved tag and zero-count literal: sticky err, no output
    q.delete();
    send(rsv());
    cycles(5);
    chk("rsv_err", 160'(err), 160'(1));
    chk("rsv_in_rd", 160'(in_rd), 160'(1));
    chk("rsv_no_out", 160'(q.size()), 160'(0));
    send(lit(6'd0, 64'hFF));
    cycles(5);
    chk("lit0_err", 160'(err), 160'(1));
    chk("lit0_in_rd", 160'(in_rd), 160'(1));
    chk("lit0_no_out", 160'(q.size()), 160'(0));

    // Oversized literal count is clamped to 32
    send(lit(6'd40, 64'h0));
    send(nrun(32'd8));
    wait_words(2, "lit40_arrive");
    cycles(5);
    chk("lit40_count", 160'(q.size()), 160'(2));
    pop_chk("lit40_w0", mkw(rep("A", 20)), 1'b0);
    pop_chk("lit40_w1", mkw({rep("A", 12), rep("N", 8)}), 1'b0);
    chk("lit40_err", 160'(err), 160'(1));

    // Asynchronous reset in the middle of a stalled NRUN 100
    q.delete();
    out_rdy = 1'b0;
    send(nrun(32'd100));
    cycles(30);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_vld", 160'(out_vld), 160'(0));
    chk("mid_rst_out_word", out_word, 160'(0));
    chk("mid_rst_out_last", 160'(out_last), 160'(0));
    chk("mid_rst_in_rd", 160'(in_rd), 160'(0));
    chk("mid_rst_err", 160'(err), 160'(0));
`ifdef NXXXX_EXP_STATS_EN
    chk("mid_rst_stat_bases", 160'(stat_bases), 160'(0));
    chk("mid_rst_stat_n", 160'(stat_n), 160'(0));
`endif
    @(posedge clk); #3;
    rst_n = 1'b1;
    q.delete();
    out_rdy = 1'b1;
    cycles(2);
    chk("post_rst_in_rd", 160'(in_rd), 160'(1));

    // Fresh stream after reset starts at slot 0
    send(lit(6'd32, 64'h1B1B1B1B1B1B1B1B));
    send(nrun(32'd8));
    wait_words(2, "post_arrive");
    cycles(5);
    chk("post_count", 160'(q.size()), 160'(2));
    pop_chk("post_w0", mkw(rep("TGCA", 5)), 1'b0);
    pop_chk("post_w1", mkw({rep("TGCA", 3), rep("N", 8)}), 1'b0);
    chk("post_err", 160'(err), 160'(0));
`ifdef NXXXX_EXP_STATS_EN
    chk("stat_bases", 160'(stat_bases), 160'(32));
    chk("stat_n", 160'(stat_n), 160'(8));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
